flash_word_fifo: RTL and testbench

FLASH_WORD_FIFO -- requirements
Module: flash_word_fifo

---
 rtl/flash_word_fifo_pkg.sv | 12 +
 rtl/flash_word_fifo_if.sv | 28 ++
 rtl/flash_word_fifo.sv | 104 ++++++++++
 tb/tb_flash_word_fifo.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/flash_word_fifo_pkg.sv
// Shared video-path constants and types used by the flash word FIFO and the RLE decoder.
package flash_word_fifo_pkg;
  localparam int FIFO_WIDTH   = 16;
  localparam int FIFO_LEVEL_W = 4;

  // Encoding is {active, outstanding} so each state maps directly onto the two fetch flags.
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    READY     = 2'b10,
    WAIT_WORD = 2'b11
  } fetch_state_e;
endpackage

// File: rtl/flash_word_fifo_if.sv
// Flash-controller and consumer handshake bundle around the flash word FIFO.
interface flash_word_fifo_if
  import flash_word_fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
);
  logic                    ctrl_start;
  logic                    ctrl_stop;
  logic                    ctrl_valid;
  logic [WIDTH-1:0]        ctrl_data;
  logic                    ctrl_continue;
  logic                    rd_en;
  logic [WIDTH-1:0]        rd_data;
  logic                    rd_empty;
  logic [FIFO_LEVEL_W-1:0] level;
  logic                    overflow;
  logic                    underflow;

  modport master (
    output ctrl_start, ctrl_stop, ctrl_valid, ctrl_data, rd_en,
    input  ctrl_continue, rd_data, rd_empty, level, overflow, underflow
  );

  modport slave (
    input  ctrl_start, ctrl_stop, ctrl_valid, ctrl_data, rd_en,
    output ctrl_continue, rd_data, rd_empty, level, overflow, underflow
  );
endinterface

// File: rtl/flash_word_fifo.sv
// First-word-fall-through word FIFO between the flash controller and the RLE decoder,
// with an inline fetch FSM that requests the next word only while there is room for it.
module flash_word_fifo
  import flash_word_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = FIFO_WIDTH
) (
  input logic              clk,
  input logic              rst_n,
  flash_word_fifo_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [FIFO_LEVEL_W-1:0] FULL_LEVEL = FIFO_LEVEL_W'(DEPTH);

  logic [WIDTH-1:0]        mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [FIFO_LEVEL_W-1:0] level_q;
  logic                    overflow_q;
  logic                    underflow_q;
  fetch_state_e            state;
  fetch_state_e            state_nxt;

  logic flush;
  logic active;
  logic empty;
  logic full;
  logic rd_fire;
  logic wr_fire;
  logic drop;
  logic cont;

  always_comb begin
    flush   = bus.ctrl_start | bus.ctrl_stop;
    active  = (state != IDLE);
    empty   = (level_q == '0);
    full    = (level_q == FULL_LEVEL);
    rd_fire = bus.rd_en & ~empty & ~flush;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a word.
    wr_fire = bus.ctrl_valid & active & ~flush & (~full | rd_fire);
    drop    = bus.ctrl_valid & active & ~flush & full & ~rd_fire;
  end

  always_comb begin
    state_nxt = state;
    cont      = 1'b0;
    if (bus.ctrl_start) begin
      state_nxt = WAIT_WORD;
    end else if (bus.ctrl_stop) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        READY: begin
          // Count this cycle's accepted word so the request never outruns free space.
          if (rst_n && ((level_q + FIFO_LEVEL_W'(wr_fire)) < FULL_LEVEL)) begin
            cont      = 1'b1;
            state_nxt = WAIT_WORD;
          end
        end
        WAIT_WORD: begin
          if (bus.ctrl_valid) state_nxt = READY;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        level_q <= '0;
      end else begin
        if (wr_fire) wr_ptr <= wr_ptr + PTR_W'(1);
        if (rd_fire) rd_ptr <= rd_ptr + PTR_W'(1);
        if (wr_fire && !rd_fire)      level_q <= level_q + FIFO_LEVEL_W'(1);
        else if (rd_fire && !wr_fire) level_q <= level_q - FIFO_LEVEL_W'(1);
      end
      if (drop) overflow_q <= 1'b1;
      if (bus.rd_en && empty && !flush) underflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= bus.ctrl_data;
  end

  assign bus.rd_data       = mem[rd_ptr];
  assign bus.rd_empty      = empty;
  assign bus.level         = level_q;
  assign bus.overflow      = overflow_q;
  assign bus.underflow     = underflow_q;
  assign bus.ctrl_continue = cont;
endmodule

// File: tb/tb_flash_word_fifo.sv
// Scenario bench for flash_word_fifo: a queue holds the words expected out of the FIFO
// and is popped and compared whenever the bench pops a word from the DUT.
module tb_flash_word_fifo;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [15:0] exp_q[$];
  logic        m_active = 1'b0;
  logic        m_ovf    = 1'b0;
  logic        m_unf    = 1'b0;

  logic        obs_cont;
  logic        did_pop;
  logic [15:0] obs_pop;
  logic [15:0] exp_pop;

  flash_word_fifo_if #(.WIDTH(16)) bus ();

  flash_word_fifo #(.DEPTH(DEPTH), .WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // Applies one cycle of stimulus, samples pre-edge outputs, updates the scoreboard.
  task automatic drive(input logic st, input logic sp, input logic v, input logic [15:0] d, input logic r);
    bus.ctrl_start = st;
    bus.ctrl_stop  = sp;
    bus.ctrl_valid = v;
    bus.ctrl_data  = d;
    bus.rd_en      = r;
    #1;
    obs_cont = bus.ctrl_continue;
    did_pop  = 1'b0;
    if (st || sp) begin
      exp_q.delete();
      m_active = st;
    end else begin
      if (r && exp_q.size() == 0) m_unf = 1'b1;
      if (r && exp_q.size() > 0) begin
        did_pop = 1'b1;
        obs_pop = bus.rd_data;
        exp_pop = exp_q.pop_front();
      end
      if (v && m_active) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else m_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    bus.ctrl_start = 1'b0;
    bus.ctrl_stop  = 1'b0;
    bus.ctrl_valid = 1'b0;
    bus.ctrl_data  = '0;
    bus.rd_en      = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (bus.ctrl_continue !== 1'b0) $display("FAIL rst_cont_during: got %b want 0", bus.ctrl_continue); else n_pass++;
    n_checks++; if (bus.rd_empty !== 1'b1) $display("FAIL rst_empty_during: got %b want 1", bus.rd_empty); else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete(); m_active = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    #1;
    n_checks++; if (bus.level !== 4'd0) $display("FAIL rst_level: got %0d want 0", bus.level); else n_pass++;
    n_checks++; if (bus.rd_empty !== 1'b1) $display("FAIL rst_empty_after: got %b want 1", bus.rd_empty); else n_pass++;
    n_checks++; if (bus.ctrl_continue !== 1'b0) $display("FAIL rst_cont_after: got %b want 0", bus.ctrl_continue); else n_pass++;
    n_checks++; if ({bus.overflow, bus.underflow} !== 2'b00) $display("FAIL rst_flags: got %b want 00", {bus.overflow, bus.underflow}); else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill();
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 16'h1111, 1'b0);
    n_checks++; if (obs_cont !== 1'b0) $display("FAIL fill_cont_v1: got %b want 0", obs_cont); else n_pass++;
    drive(1'b0, 1'b0, 1'b1, 16'h2222, 1'b0);
    n_checks++; if (obs_cont !== 1'b1) $display("FAIL fill_cont_v2: got %b want 1", obs_cont); else n_pass++;
    drive(1'b0, 1'b0, 1'b1, 16'h3333, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 16'h4444, 1'b0);
    n_checks++; if (obs_cont !== 1'b0) $display("FAIL fill_cont_after_v3: got %b want 0", obs_cont); else n_pass++;
    idle();
    n_checks++; if (obs_cont !== 1'b0) $display("FAIL fill_cont_full: got %b want 0", obs_cont); else n_pass++;
    n_checks++; if (bus.level !== 4'(exp_q.size()) || bus.level !== 4'd4) $display("FAIL fill_level: got %0d want 4", bus.level); else n_pass++;
    n_checks++; if (bus.rd_data !== exp_q[0]) $display("FAIL fill_head: got %h want %h", bus.rd_data, exp_q[0]); else n_pass++;
    n_checks++; if (bus.overflow !== m_ovf) $display("FAIL fill_overflow: got %b want %b", bus.overflow, m_ovf); else n_pass++;
  endtask

  task automatic test_simul();
    drive(1'b0, 1'b0, 1'b1, 16'h5555, 1'b1);
    n_checks++; if (!did_pop || obs_pop !== exp_pop) $display("FAIL simul_pop: got %h want %h", obs_pop, exp_pop); else n_pass++;
    n_checks++; if (bus.level !== 4'(exp_q.size())) $display("FAIL simul_level: got %0d want %0d", bus.level, exp_q.size()); else n_pass++;
    n_checks++; if (bus.rd_data !== exp_q[0]) $display("FAIL simul_head: got %h want %h", bus.rd_data, exp_q[0]); else n_pass++;
    n_checks++; if (bus.overflow !== 1'b0) $display("FAIL simul_overflow: got %b want 0", bus.overflow); else n_pass++;
  endtask

  task automatic test_overflow();
    drive(1'b0, 1'b0, 1'b1, 16'h6666, 1'b0);
    n_checks++; if (bus.overflow !== m_ovf || !m_ovf) $display("FAIL ovf_set: got %b want 1", bus.overflow); else n_pass++;
    n_checks++; if (bus.level !== 4'(exp_q.size())) $display("FAIL ovf_level: got %0d want %0d", bus.level, exp_q.size()); else n_pass++;
    idle();
    idle();
    n_checks++; if (bus.overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", bus.overflow); else n_pass++;
  endtask

  task automatic test_pop_full();
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    n_checks++; if (!did_pop || obs_pop !== exp_pop) $display("FAIL popfull_pop: got %h want %h", obs_pop, exp_pop); else n_pass++;
    n_checks++; if (bus.level !== 4'(exp_q.size())) $display("FAIL popfull_level: got %0d want %0d", bus.level, exp_q.size()); else n_pass++;
    n_checks++; if (bus.rd_data !== exp_q[0]) $display("FAIL popfull_head: got %h want %h", bus.rd_data, exp_q[0]); else n_pass++;
    idle();
    n_checks++; if (obs_cont !== 1'b1) $display("FAIL popfull_cont_pulse: got %b want 1", obs_cont); else n_pass++;
    idle();
    n_checks++; if (obs_cont !== 1'b0) $display("FAIL popfull_cont_once: got %b want 0", obs_cont); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
      n_checks++; if (!did_pop || obs_pop !== exp_pop) $display("FAIL drain_order_%0d: got %h want %h", i, obs_pop, exp_pop); else n_pass++;
    end
    n_checks++; if (bus.rd_empty !== 1'b1) $display("FAIL drain_empty: got %b want 1", bus.rd_empty); else n_pass++;
  endtask

  task automatic test_underflow();
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    n_checks++; if (bus.underflow !== m_unf || !m_unf) $display("FAIL unf_set: got %b want 1", bus.underflow); else n_pass++;
    n_checks++; if (bus.level !== 4'd0 || bus.rd_empty !== 1'b1) $display("FAIL unf_level: got %0d/%b want 0/1", bus.level, bus.rd_empty); else n_pass++;
  endtask

  task automatic test_start_flush();
    drive(1'b0, 1'b0, 1'b1, 16'hA001, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 16'hA002, 1'b0);
    n_checks++; if (bus.level !== 4'd2) $display("FAIL flush_pre_level: got %0d want 2", bus.level); else n_pass++;
    drive(1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b1);
    n_checks++; if (bus.level !== 4'(exp_q.size()) || bus.rd_empty !== 1'b1) $display("FAIL flush_level: got %0d/%b want 0/1", bus.level, bus.rd_empty); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      idle();
      n_checks++; if (obs_cont !== 1'b0) $display("FAIL flush_cont_wait_%0d: got %b want 0", i, obs_cont); else n_pass++;
    end
    drive(1'b0, 1'b0, 1'b1, 16'hC001, 1'b0);
    idle();
    n_checks++; if (obs_cont !== 1'b1) $display("FAIL flush_cont_after_valid: got %b want 1", obs_cont); else n_pass++;
    n_checks++; if (bus.rd_data !== exp_q[0]) $display("FAIL flush_head: got %h want %h", bus.rd_data, exp_q[0]); else n_pass++;
    n_checks++; if ({bus.overflow, bus.underflow} !== {m_ovf, m_unf}) $display("FAIL flush_sticky: got %b want %b", {bus.overflow, bus.underflow}, {m_ovf, m_unf}); else n_pass++;
  endtask

  task automatic test_stop();
    drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 16'hD001, 1'b0);
    idle();
    n_checks++; if (bus.level !== 4'(exp_q.size()) || bus.rd_empty !== 1'b1) $display("FAIL stop_discard: got %0d/%b want 0/1", bus.level, bus.rd_empty); else n_pass++;
    n_checks++; if (obs_cont !== 1'b0) $display("FAIL stop_cont: got %b want 0", obs_cont); else n_pass++;
    drive(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 16'hE001, 1'b0);
    n_checks++; if (bus.level !== 4'(exp_q.size()) || bus.rd_data !== 16'hE001) $display("FAIL start_wins: got %0d/%h want 1/e001", bus.level, bus.rd_data); else n_pass++;
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b0, 1'b1, 16'hE002, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 16'hE003, 1'b0);
    n_checks++; if (bus.level !== 4'd3) $display("FAIL midrst_pre_level: got %0d want 3", bus.level); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.ctrl_continue !== 1'b0) $display("FAIL midrst_cont_during: got %b want 0", bus.ctrl_continue); else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete(); m_active = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    #1;
    n_checks++; if (bus.level !== 4'd0 || bus.rd_empty !== 1'b1) $display("FAIL midrst_level: got %0d/%b want 0/1", bus.level, bus.rd_empty); else n_pass++;
    n_checks++; if (bus.ctrl_continue !== 1'b0) $display("FAIL midrst_cont_after: got %b want 0", bus.ctrl_continue); else n_pass++;
    n_checks++; if ({bus.overflow, bus.underflow} !== 2'b00) $display("FAIL midrst_flags: got %b want 00", {bus.overflow, bus.underflow}); else n_pass++;
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b1, 16'hF001, 1'b0);
    n_checks++; if (bus.level !== 4'(exp_q.size())) $display("FAIL midrst_inactive: got %0d want %0d", bus.level, exp_q.size()); else n_pass++;
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.ctrl_start = 1'b0;
    bus.ctrl_stop  = 1'b0;
    bus.ctrl_valid = 1'b0;
    bus.ctrl_data  = '0;
    bus.rd_en      = 1'b0;
    test_reset();
    test_fill();
    test_simul();
    test_overflow();
    test_pop_full();
    test_underflow();
    test_start_flush();
    test_stop();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
